mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between instruction fetch (I) and load/store (D).
//  One transaction in flight at a time: grant, issue, fixed-latency wait, respond.
//  D has priority, with a starvation guard for I. flush_i squashes in-flight fetch responses.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: data side wins unless fetch has been starved for STARVE_MAX grants.
module mem_arb_pick #(
    parameter int SCW        = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic           can_grant,
    input  logic           i_req,
    input  logic           d_req,
    input  logic [SCW-1:0] starve_cnt,
    output logic           gnt_i,
    output logic           gnt_d
);

    logic force_i;

    always_comb begin
        force_i = (starve_cnt == SCW'(STARVE_MAX)) && i_req;
        gnt_d   = can_grant && d_req && !force_i;
        gnt_i   = can_grant && i_req && !gnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (I) and load/store (D): one transaction in
// flight, fixed memory latency, D priority with a starvation guard for I.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              i_req_i,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DWIDTH-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_gnt_o,
    output logic              d_done_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic [2:0]        mem_funct3_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output state_e            dbg_state
);

    localparam int LCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);

    // Handshake: a requester raises req with its payload and holds both stable until it
    // sees gnt high; gnt is combinational in that same cycle and the payload is latched then.
    state_e           state_q, state_d;
    owner_e           owner_q;
    logic             we_q;
    logic [LCW-1:0]   lat_q;
    logic [SCW-1:0]   starve_q;
    logic             squash_q;
    logic             can_grant, gnt_i, gnt_d, any_gnt, resp;

    assign can_grant = !rst && (state_q == IDLE || state_q == RESP);
    assign any_gnt   = gnt_i || gnt_d;
    assign dbg_state = state_q;

    mem_arb_pick #(
        .SCW        (SCW),
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .can_grant  (can_grant),
        .i_req      (i_req_i),
        .d_req      (d_req_i),
        .starve_cnt (starve_q),
        .gnt_i      (gnt_i),
        .gnt_d      (gnt_d)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_gnt) state_d = ISSUE;
            ISSUE:   state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (lat_q == '0) state_d = RESP;
            RESP:    state_d = any_gnt ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_I;
            we_q         <= 1'b0;
            lat_q        <= '0;
            starve_q     <= '0;
            squash_q     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_funct3_o <= '0;
        end else begin
            if (any_gnt) begin
                owner_q      <= gnt_d ? OWN_D : OWN_I;
                we_q         <= gnt_d && d_we_i;
                mem_addr_o   <= gnt_d ? d_addr_i : i_addr_i;
                mem_wdata_o  <= (gnt_d && d_we_i) ? d_wdata_i : '0;
                mem_funct3_o <= gnt_d ? d_funct3_i : FUNCT3_WORD;
            end
            if (state_q == ISSUE)     lat_q <= LCW'(MEM_LATENCY - 2);
            else if (state_q == WAIT) lat_q <= lat_q - LCW'(1);
            if (gnt_i)
                starve_q <= '0;
            else if (gnt_d && i_req_i && starve_q != SCW'(STARVE_MAX))
                starve_q <= starve_q + SCW'(1);
            // A new grant starts a fresh squash decision; otherwise the flag only
            // accumulates while an I transaction is in flight and drops after RESP.
            if (any_gnt)
                squash_q <= gnt_i && flush_i;
            else if (state_q == RESP)
                squash_q <= 1'b0;
            else if (state_q != IDLE && owner_q == OWN_I && flush_i)
                squash_q <= 1'b1;
        end
    end

    always_comb begin
        resp           = !rst && (state_q == RESP);
        i_gnt_o        = gnt_i;
        d_gnt_o        = gnt_d;
        mem_read_en_o  = !rst && (state_q == ISSUE) && !we_q;
        mem_write_en_o = !rst && (state_q == ISSUE) && we_q;
        i_rvalid_o     = resp && (owner_q == OWN_I) && !squash_q && !flush_i;
        i_rdata_o      = i_rvalid_o ? mem_rdata_i : '0;
        d_done_o       = resp && (owner_q == OWN_D);
        d_rdata_o      = (d_done_o && !we_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// grants, memory accesses and responses; a monitor compares them as the DUT produces them.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        i_req_i = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [2:0]  d_funct3_i = '0;
    logic        i_gnt_o, i_rvalid_o, d_gnt_o, d_done_o, mem_read_en_o, mem_write_en_o;
    logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [2:0]  mem_funct3_o;
    state_e      dbg_state;

    mem_port_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_funct3_i(d_funct3_i), .d_gnt_o(d_gnt_o), .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_funct3_o(mem_funct3_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_rdata_i(mem_rdata_i), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endfunction

    // ---------------- memory macro model ----------------
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0100_0000) return 32'h0000_8067;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic        rd_v [LAT];
    logic [31:0] rd_a [LAT];
    always @(posedge clk) begin
        rd_v[0] <= rst ? 1'b0 : mem_read_en_o;
        rd_a[0] <= mem_addr_o;
        for (int k = 1; k < LAT; k++) begin
            rd_v[k] <= rst ? 1'b0 : rd_v[k-1];
            rd_a[k] <= rd_a[k-1];
        end
    end
    // Outside a read's data window the bus carries junk, so stores must not leak it.
    assign mem_rdata_i = rd_v[LAT-1] ? rom(rd_a[LAT-1]) : {16'hA5A5, cyc[15:0]};

    // ---------------- driver tasks / requester processes ----------------
    typedef struct { logic [31:0] addr; int gap; } i_item_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] f3; int gap; } d_item_t;
    i_item_t i_todo[$];
    d_item_t d_todo[$];
    logic i_gnt_seen = 1'b0;
    logic d_gnt_seen = 1'b0;

    task automatic push_i(input logic [31:0] a, input int gap);
        i_item_t it;
        it.addr = a; it.gap = gap;
        i_todo.push_back(it);
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int gap);
        d_item_t it;
        it.we = we; it.addr = a; it.wdata = wd; it.f3 = f3; it.gap = gap;
        d_todo.push_back(it);
    endtask

    task automatic push_rand_d(input int gmax);
        logic [2:0] load_f3 [5];
        logic       we;
        load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        we = 1'($urandom_range(0, 1));
        push_d(we, $urandom, $urandom,
               we ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)],
               int'($urandom_range(0, gmax)));
    endtask

    initial begin
        int wait_n;
        i_item_t it;
        wait_n = 0;
        forever begin
            @(posedge clk); #1;
            if (i_req_i && i_gnt_seen) i_req_i = 1'b0;
            if (!i_req_i && i_todo.size() > 0) begin
                if (wait_n < i_todo[0].gap) wait_n++;
                else begin
                    it = i_todo.pop_front();
                    i_req_i = 1'b1; i_addr_i = it.addr; wait_n = 0;
                end
            end
        end
    end

    initial begin
        int wait_n;
        d_item_t it;
        wait_n = 0;
        forever begin
            @(posedge clk); #1;
            if (d_req_i && d_gnt_seen) d_req_i = 1'b0;
            if (!d_req_i && d_todo.size() > 0) begin
                if (wait_n < d_todo[0].gap) wait_n++;
                else begin
                    it = d_todo.pop_front();
                    d_req_i = 1'b1; d_we_i = it.we; d_addr_i = it.addr;
                    d_wdata_i = it.wdata; d_funct3_i = it.f3; wait_n = 0;
                end
            end
        end
    end

    // ---------------- reference model + scoreboard queues ----------------
    typedef struct { int unsigned cyc; logic [31:0] data; logic squash; } resp_t;
    typedef struct { int unsigned cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] f3; } acc_t;
    resp_t exp_i_q[$];
    resp_t exp_d_q[$];
    acc_t  exp_acc_q[$];

    initial begin
        int unsigned free_c;
        int          starve;
        logic        ei, ed, prev_i_req, prev_d_req;
        resp_t       r;
        acc_t        a;
        free_c = 0; starve = 0; prev_i_req = 1'b0; prev_d_req = 1'b0;
        forever begin
            @(negedge clk);
            assert (!(prev_i_req && !i_gnt_seen && !i_req_i)) else $error("i_req dropped before grant");
            assert (!(prev_d_req && !d_gnt_seen && !d_req_i)) else $error("d_req dropped before grant");
            if (rst) begin
                check("i_gnt_in_rst", {31'd0, i_gnt_o}, 32'd0);
                check("d_gnt_in_rst", {31'd0, d_gnt_o}, 32'd0);
                free_c = 0; starve = 0;
                exp_i_q.delete(); exp_d_q.delete(); exp_acc_q.delete();
            end else begin
                ed = (cyc >= free_c) && d_req_i && !(starve == SMAX && i_req_i);
                ei = (cyc >= free_c) && i_req_i && !ed;
                check("i_gnt", {31'd0, i_gnt_o}, {31'd0, ei});
                check("d_gnt", {31'd0, d_gnt_o}, {31'd0, ed});
                if (flush_i && exp_i_q.size() > 0 && exp_i_q[$].cyc >= cyc) begin
                    r = exp_i_q.pop_back(); r.squash = 1'b1; exp_i_q.push_back(r);
                end
                if (ei || ed) begin
                    free_c = cyc + 1 + LAT;
                    a.cyc = cyc + 1; a.we = ed && d_we_i; a.addr = ed ? d_addr_i : i_addr_i;
                    a.wdata = d_wdata_i; a.f3 = ed ? d_funct3_i : 3'b010;
                    exp_acc_q.push_back(a);
                    r.cyc = cyc + 1 + LAT; r.squash = 1'b0;
                    if (ei) begin
                        r.data = rom(i_addr_i); r.squash = flush_i;
                        exp_i_q.push_back(r);
                        starve = 0;
                    end else begin
                        r.data = d_we_i ? 32'd0 : rom(d_addr_i);
                        exp_d_q.push_back(r);
                        if (i_req_i && starve < SMAX) starve++;
                    end
                end
            end
            i_gnt_seen = i_gnt_o; d_gnt_seen = d_gnt_o;
            prev_i_req = i_req_i && !i_gnt_o; prev_d_req = d_req_i && !d_gnt_o;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        resp_t r;
        acc_t  a;
        forever begin
            @(negedge clk); #2;
            if (exp_i_q.size() > 0 && exp_i_q[0].cyc == cyc) begin
                r = exp_i_q.pop_front();
                if (r.squash) check("i_rvalid_squashed", {31'd0, i_rvalid_o}, 32'd0);
                else begin
                    check("i_rvalid", {31'd0, i_rvalid_o}, 32'd1);
                    check("i_rdata", i_rdata_o, r.data);
                end
            end else check("i_rvalid_idle", {31'd0, i_rvalid_o}, 32'd0);
            if (exp_d_q.size() > 0 && exp_d_q[0].cyc == cyc) begin
                r = exp_d_q.pop_front();
                check("d_done", {31'd0, d_done_o}, 32'd1);
                check("d_rdata", d_rdata_o, r.data);
            end else check("d_done_idle", {31'd0, d_done_o}, 32'd0);
            if (exp_acc_q.size() > 0 && exp_acc_q[0].cyc == cyc) begin
                a = exp_acc_q.pop_front();
                check("mem_read_en", {31'd0, mem_read_en_o}, {31'd0, !a.we});
                check("mem_write_en", {31'd0, mem_write_en_o}, {31'd0, a.we});
                check("mem_addr", mem_addr_o, a.addr);
                check("mem_funct3", {29'd0, mem_funct3_o}, {29'd0, a.f3});
                if (a.we) check("mem_wdata", mem_wdata_o, a.wdata);
            end else check("mem_en_idle", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
        end
    end

    // ---------------- stimulus phases ----------------
    function automatic logic busy();
        return (i_todo.size() > 0) || (d_todo.size() > 0) || i_req_i || d_req_i ||
               (exp_i_q.size() > 0) || (exp_d_q.size() > 0) || (exp_acc_q.size() > 0);
    endfunction

    task automatic drain(input string name, input int limit, input logic rand_flush);
        int n;
        n = 0;
        while (busy() && n < limit) begin
            @(posedge clk); #1;
            flush_i = rand_flush && ($urandom_range(0, 11) == 0);
            n++;
        end
        flush_i = 1'b0;
        check(name, {31'd0, busy()}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_strobes"}, {25'd0, i_gnt_o, i_rvalid_o, d_gnt_o, d_done_o,
              mem_read_en_o, mem_write_en_o, 1'b0}, 32'd0);
        check({name, "_i_rdata"}, i_rdata_o, 32'd0);
        check({name, "_d_rdata"}, d_rdata_o, 32'd0);
        check({name, "_mem_addr"}, mem_addr_o, 32'd0);
        check({name, "_mem_wdata"}, mem_wdata_o, 32'd0);
        check({name, "_mem_funct3"}, {29'd0, mem_funct3_o}, 32'd0);
        check({name, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
    endtask

    task automatic wait_i_gnt(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!i_gnt_o && n < 50);
        check(name, {31'd0, i_gnt_o}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        push_i(32'h0100_0000, 0);
        drain("drain_fetch", 200, 1'b0);

        push_d(1'b0, 32'h0100_0010, 32'd0, 3'b010, 0);
        push_i(32'h0100_0040, 0);
        drain("drain_same_cycle", 200, 1'b0);

        push_d(1'b1, 32'h0100_0020, 32'hDEAD_BEEF, 3'b010, 0);
        drain("drain_store", 200, 1'b0);

        for (int k = 0; k < 12; k++) push_rand_d(0);
        push_i(32'h0100_0100, 0);
        push_i(32'h0100_0104, 0);
        drain("drain_starve", 400, 1'b0);

        push_i(32'h0100_0200, 0);
        wait_i_gnt("flush_gnt");
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        push_i(32'h0100_0204, 0);
        drain("drain_flush", 200, 1'b0);

        for (int k = 0; k < 200; k++) begin
            push_i($urandom, int'($urandom_range(0, 6)));
            push_rand_d(5);
        end
        drain("drain_random", 20000, 1'b1);

        push_i(32'h0100_0300, 0);
        wait_i_gnt("rst_gnt");
        @(posedge clk);
        @(posedge clk); #1;
        check("rst_in_wait_state", {30'd0, dbg_state}, {30'd0, WAIT});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_rst");
        repeat (6) @(posedge clk);
        push_i(32'h0100_0000, 0);
        drain("drain_after_rst", 200, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
